// File: rtl/capsense_csd_scan_ctrl.sv
// rtl/capsense_csd_scan_ctrl.sv - CSD scan sequencer with optional PRS-dithered precharge strobe
module capsense_csd_scan_ctrl #(
   parameter int NumSensors = 8,
   parameter bit PrsEnable  = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       scan_req,
   input  logic       abort,
   input  logic [7:0] divider,
   input  logic [7:0] settle_cycles,
   input  logic       meas_done,
   output logic       meas_start,
   output logic       pulse,
   output logic [3:0] sensor_sel,
   output logic       sensor_en,
   output logic       busy,
   output logic       sensor_done,
   output logic       scan_done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_START   = 3'd2,
      S_RELEASE = 3'd3,
      S_NEXT    = 3'd4
   } state_t;

   localparam logic [3:0] LastSel = 4'(NumSensors - 1);

   state_t     r_state;
   logic [7:0] r_settle;
   logic [3:0] r_sensor_sel;
   logic       r_meas_start;
   logic       r_sensor_en;
   logic       r_busy;
   logic       r_sensor_done;
   logic       r_scan_done;

   logic [7:0] r_strobe;
   logic [7:0] r_lfsr;
   logic       r_pulse;

   logic [8:0] w_sum;
   logic [7:0] w_reload;
   logic       w_fb;
   logic       w_last;

   assign w_last = (r_sensor_sel == LastSel);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_settle      <= 8'd0;
         r_sensor_sel  <= 4'd0;
         r_meas_start  <= 1'b0;
         r_sensor_en   <= 1'b0;
         r_busy        <= 1'b0;
         r_sensor_done <= 1'b0;
         r_scan_done   <= 1'b0;
      end else begin
         r_sensor_done <= 1'b0;
         r_scan_done   <= 1'b0;
         // Abort and run-disable override every other transition, without completion pulses.
         if ((r_state != S_IDLE) && (abort || !enable)) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_sensor_en  <= 1'b0;
            r_meas_start <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (enable && scan_req) begin
                     r_state      <= S_SELECT;
                     r_sensor_sel <= 4'd0;
                     r_settle     <= settle_cycles;
                     r_busy       <= 1'b1;
                     r_sensor_en  <= 1'b1;
                  end
               end
               S_SELECT: begin
                  if (r_settle == 8'd0) begin
                     r_state      <= S_START;
                     r_meas_start <= 1'b1;
                  end else begin
                     r_settle <= r_settle - 8'd1;
                  end
               end
               S_START: begin
                  if (meas_done) begin
                     r_state      <= S_RELEASE;
                     r_meas_start <= 1'b0;
                  end
               end
               S_RELEASE: begin
                  if (!meas_done) begin
                     r_state       <= S_NEXT;
                     r_sensor_en   <= 1'b0;
                     r_sensor_done <= 1'b1;
                     r_scan_done   <= w_last;
                  end
               end
               S_NEXT: begin
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state      <= S_SELECT;
                     r_sensor_sel <= r_sensor_sel + 4'd1;
                     r_settle     <= settle_cycles;
                     r_sensor_en  <= 1'b1;
                  end
               end
               default: begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_sensor_en  <= 1'b0;
                  r_meas_start <= 1'b0;
               end
            endcase
         end
      end
   end

   // Dithered reload adds the two LFSR LSBs to the divider, clamped to the 8-bit counter range.
   assign w_sum    = {1'b0, divider} + {7'd0, r_lfsr[1:0]};
   assign w_reload = PrsEnable ? (w_sum[8] ? 8'hFF : w_sum[7:0]) : divider;
   assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_strobe <= 8'd0;
         r_lfsr   <= 8'hFF;
         r_pulse  <= 1'b0;
      end else if (!enable) begin
         r_strobe <= w_reload;
         r_pulse  <= 1'b0;
      end else if (r_strobe == 8'd0) begin
         r_strobe <= w_reload;
         r_pulse  <= 1'b1;
         r_lfsr   <= {r_lfsr[6:0], w_fb};
      end else begin
         r_strobe <= r_strobe - 8'd1;
         r_pulse  <= 1'b0;
      end
   end

   assign meas_start  = r_meas_start;
   assign pulse       = r_pulse;
   assign sensor_sel  = r_sensor_sel;
   assign sensor_en   = r_sensor_en;
   assign busy        = r_busy;
   assign sensor_done = r_sensor_done;
   assign scan_done   = r_scan_done;

endmodule
